data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the word-index width (2**ADDR_W words of 32 bits).
REQ-002 SHALL have parameter FIFO_LOG2, default 2, giving the TX FIFO depth of 2**FIFO_LOG2 bytes.
REQ-003 SHALL have clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have addr  input  32  byte address from the CPU MEM stage.
REQ-006 SHALL have w_en  input  1  store strobe, qualified by addr and w_data.
REQ-007 SHALL have w_data  input  32  store data.
REQ-008 SHALL have r_data  output  32  load data, combinational from addr.
REQ-009 SHALL have tx_valid  output  1  TX FIFO non-empty.
REQ-010 SHALL have tx_data  output  8  TX FIFO head byte.
REQ-011 SHALL have tx_ready  input  1  consumer accepts the head byte.

Function
REQ-012 SHALL map MMIO_TX = 32'hFFFF_FF00 and MMIO_STAT = 32'hFFFF_FF04; all other addresses are RAM, indexed by addr[ADDR_W+1:2], with addr[1:0] ignored.
REQ-013 SHALL write w_data to RAM[index] on the clock edge when w_en=1 and addr is RAM.
REQ-014 SHALL drive r_data = RAM[index] for a RAM addr with zero-cycle latency, and a store and a load to the same word in the same cycle SHALL return the old data.
REQ-015 SHALL drive r_data = {26'b0, ovf, count[2:0], full, empty} for MMIO_STAT and r_data = 0 for MMIO_TX.
REQ-016 SHALL push w_data[7:0] into the FIFO on an edge with w_en=1, addr=MMIO_TX and the FIFO not full, leaving RAM unchanged.
REQ-017 SHALL drop a push to a full FIFO and set the sticky ovf bit, unless a pop occurs in the same cycle, in which case the push is accepted and ovf is unchanged.
REQ-018 SHALL pop the head on an edge with tx_valid=1 and tx_ready=1, and tx_data SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-019 SHALL keep count unchanged on a simultaneous push and pop; wptr and rptr SHALL wrap modulo depth, and count SHALL range 0 to depth.
REQ-020 SHALL drive tx_valid = (count != 0), empty = (count == 0) and full = (count == depth); a pushed byte SHALL appear on tx_data no earlier than the cycle after the push.
REQ-021 SHALL clear ovf on an edge with w_en=1, addr=MMIO_STAT and w_data[0]=1, with a clear taking priority over a same-cycle overflow set.
REQ-022 SHALL ignore w_data bits other than bit 0 on writes to MMIO_STAT.

Reset
REQ-023 SHALL, while rst_n=0, clear wptr, rptr, count and ovf, so that tx_valid=0, tx_data is don't-care and the status word reads 32'h0000_0001.
REQ-024 SHALL NOT reset RAM contents, and SHALL leave RAM unchanged when rst_n is asserted mid-operation.
REQ-025 SHALL discard all queued bytes when rst_n is asserted mid-transfer, and SHALL accept no push or pop while rst_n=0.

Configuration
REQ-026 SHALL, with macro DATA_MEM_RESP_MMIO_EN defined, implement REQ-012 and REQ-015 through REQ-022 as specified.
REQ-027 SHALL, without DATA_MEM_RESP_MMIO_EN, treat every address as RAM (MMIO addresses alias by index), tie tx_valid=0 and tx_data=0, ignore tx_ready, and contain no FIFO logic.

Verification
REQ-028 SHALL cover RAM round-trip: store 32'hDEAD_BEEF to 0x40, then load 0x40 -> r_data=32'hDEAD_BEEF, and load 0x41 -> the same value.
REQ-029 SHALL cover FIFO ordering: with tx_ready=0, push 0x11, 0x22, 0x33; status reads 32'h0000_000C; then set tx_ready=1 -> tx_data=0x11, 0x22, 0x33 on consecutive cycles, then tx_valid=0.
REQ-030 SHALL cover overflow: push 5 bytes with tx_ready=0 -> status reads 32'h0000_0032; then write 1 to MMIO_STAT -> status reads 32'h0000_0012.
REQ-031 SHALL cover full push-and-pop: FIFO full and tx_ready=1 during a push of 0xAA -> count stays 4, ovf stays 0, and 0xAA is popped fourth.
REQ-032 SHALL cover reset mid-transfer: 2 bytes queued, rst_n low for one cycle -> tx_valid=0, status=32'h0000_0001, and RAM word 0x40 still reads 32'hDEAD_BEEF.
REQ-033 SHALL cover the build without the macro: store 32'h5 to 32'hFFFF_FF00 -> tx_valid stays 0, and load RAM index 32'hFFFF_FF00[ADDR_W+1:2] -> 32'h5.

Source files
------------

// File: rtl/data_mem_resp.sv
// data_mem_resp: word-addressed data RAM for the CPU MEM stage, with an
// optional memory-mapped byte TX FIFO and status register.
// Optional feature macro: DATA_MEM_RESP_MMIO_EN. When it is defined, the
// MMIO_TX and MMIO_STAT addresses and the TX FIFO are built. When it is
// undefined, every address maps to RAM and the TX port is tied off.
module data_mem_resp #(
  parameter int ADDR_W    = 8,
  parameter int FIFO_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        w_en,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  logic [ADDR_W-1:0] idx;
  logic [31:0]       mem_q [2**ADDR_W];
  logic              ram_we;

  assign idx = addr[ADDR_W+1:2];

`ifdef DATA_MEM_RESP_MMIO_EN
  localparam int                 DEPTH     = 2**FIFO_LOG2;
  localparam logic [31:0]        MMIO_TX   = 32'hFFFF_FF00;
  localparam logic [31:0]        MMIO_STAT = 32'hFFFF_FF04;
  localparam logic [FIFO_LOG2:0] CNT_FULL  = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2:0] CNT_ONE   = (FIFO_LOG2+1)'(1);

  logic                 is_tx, is_stat;
  logic [7:0]           fifo_q [DEPTH];
  logic [FIFO_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_LOG2:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 full, empty, push_req, push, pop;
  logic [31:0]          count_ext, status;

  assign is_tx     = (addr == MMIO_TX);
  assign is_stat   = (addr == MMIO_STAT);
  assign ram_we    = w_en && !is_tx && !is_stat;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign tx_valid  = !empty;
  assign tx_data   = fifo_q[rptr_q];

  // A pop frees a slot in the same edge, so a push to a full FIFO is
  // accepted when the consumer is draining.
  assign pop       = tx_valid && tx_ready;
  assign push_req  = w_en && is_tx;
  assign push      = push_req && (!full || pop);

  assign count_ext = 32'(count_q);
  assign status    = {26'b0, ovf_q, count_ext[2:0], full, empty};

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Clear wins over a same-cycle overflow set.
    if (push_req && !push)          ovf_d = 1'b1;
    if (w_en && is_stat && w_data[0]) ovf_d = 1'b0;
  end

  // FIFO control state; reset discards any queued bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO byte storage; contents are only meaningful between rptr and wptr.
  always_ff @(posedge clk) begin
    if (push && rst_n) fifo_q[wptr_q] <= w_data[7:0];
  end

  // Load mux: status word, TX register reads as zero, otherwise RAM.
  always_comb begin
    r_data = mem_q[idx];
    if (is_stat)    r_data = status;
    else if (is_tx) r_data = '0;
  end
`else
  logic unused_inputs;

  assign ram_we   = w_en;
  assign tx_valid = 1'b0;
  assign tx_data  = 8'h00;
  assign r_data   = mem_q[idx];
  assign unused_inputs = ^{tx_ready, addr[1:0], addr[31:ADDR_W+2]};
`endif

  // RAM write port; loads see the pre-edge word, giving read-old-data.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; contents survive rst_n, and stores are held off while it is low.
    if (ram_we && rst_n) mem_q[idx] <= w_data;
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench for data_mem_resp. MMIO/FIFO scenarios are
// compiled in when DATA_MEM_RESP_MMIO_EN is defined; the default build
// exercises the RAM-only configuration.
module tb_data_mem_resp;

  localparam logic [31:0] MMIO_TX   = 32'hFFFF_FF00;
  localparam logic [31:0] MMIO_STAT = 32'hFFFF_FF04;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        w_en;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  data_mem_resp #(.ADDR_W(8), .FIFO_LOG2(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .w_en     (w_en),
    .w_data   (w_data),
    .r_data   (r_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; w_data = d; w_en = 1'b1;
    step();
    w_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; addr = 32'h0; w_en = 1'b0; w_data = 32'h0; tx_ready = 1'b0;
    #2;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid);
    end
`ifdef DATA_MEM_RESP_MMIO_EN
    addr = MMIO_STAT; #1;
    checks++;
    if (r_data !== 32'h0000_0001) begin
      errors++; $display("FAIL reset_status: got %h expected 00000001", r_data);
    end
`else
    checks++;
    if (tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data);
    end
`endif
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ram_roundtrip();
    store(32'h40, 32'hDEAD_BEEF);
    addr = 32'h40; #1;
    checks++;
    if (r_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_load_40: got %h expected deadbeef", r_data);
    end
    addr = 32'h41; #1;
    checks++;
    if (r_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_load_41: got %h expected deadbeef", r_data);
    end
    store(32'h44, 32'h0BAD_F00D);
    addr = 32'h43; #1;
    checks++;
    if (r_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_neighbour_40: got %h expected deadbeef", r_data);
    end
    addr = 32'h46; #1;
    checks++;
    if (r_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL ram_load_44: got %h expected 0badf00d", r_data);
    end
  endtask

  task automatic test_read_old_data();
    store(32'h80, 32'h1234_5678);
    addr = 32'h80; w_data = 32'hCAFE_F00D; w_en = 1'b1; #1;
    checks++;
    if (r_data !== 32'h1234_5678) begin
      errors++; $display("FAIL same_cycle_old: got %h expected 12345678", r_data);
    end
    step();
    w_en = 1'b0; #1;
    checks++;
    if (r_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL after_store_new: got %h expected cafef00d", r_data);
    end
  endtask

`ifdef DATA_MEM_RESP_MMIO_EN
  task automatic test_fifo_order();
    logic [7:0] exp_bytes [3];
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
    store(32'h300, 32'h0000_0077);
    tx_ready = 1'b0;
    addr = MMIO_TX; w_data = 32'hFFFF_FF11; w_en = 1'b1; #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL push_not_early: got tx_valid %b expected 0", tx_valid);
    end
    step();
    store(MMIO_TX, 32'h0000_0022);
    store(MMIO_TX, 32'h0000_0033);
    addr = MMIO_STAT; #1;
    checks++;
    if (r_data !== 32'h0000_000C) begin
      errors++; $display("FAIL order_status: got %h expected 0000000c", r_data);
    end
    addr = MMIO_TX; #1;
    checks++;
    if (r_data !== 32'h0) begin
      errors++; $display("FAIL tx_reads_zero: got %h expected 00000000", r_data);
    end
    addr = 32'h300; #1;
    checks++;
    if (r_data !== 32'h0000_0077) begin
      errors++; $display("FAIL ram_alias_untouched: got %h expected 00000077", r_data);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i]) begin
        errors++;
        $display("FAIL order_pop%0d: got valid %b data %h expected valid 1 data %h",
                 i, tx_valid, tx_data, exp_bytes[i]);
      end
      step();
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL order_drained: got tx_valid %b expected 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(MMIO_TX, 32'(8'hA0 + i));
    addr = MMIO_STAT; #1;
    checks++;
    if (r_data !== 32'h0000_0032) begin
      errors++; $display("FAIL ovf_status: got %h expected 00000032", r_data);
    end
    #1;
    checks++;
    if (tx_data !== 8'hA0) begin
      errors++; $display("FAIL ovf_head_stable: got %h expected a0", tx_data);
    end
    store(MMIO_STAT, 32'hFFFF_FFFE);
    addr = MMIO_STAT; #1;
    checks++;
    if (r_data !== 32'h0000_0032) begin
      errors++; $display("FAIL stat_bit0_only: got %h expected 00000032", r_data);
    end
    store(MMIO_STAT, 32'h0000_0001);
    addr = MMIO_STAT; #1;
    checks++;
    if (r_data !== 32'h0000_0012) begin
      errors++; $display("FAIL ovf_cleared: got %h expected 00000012", r_data);
    end
    tx_ready = 1'b1;
    repeat (4) step();
    tx_ready = 1'b0; #1;
    checks++;
    if (r_data !== 32'h0000_0001) begin
      errors++; $display("FAIL ovf_drained: got %h expected 00000001", r_data);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_bytes [4];
    exp_bytes[0] = 8'h02; exp_bytes[1] = 8'h03; exp_bytes[2] = 8'h04; exp_bytes[3] = 8'hAA;
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) store(MMIO_TX, 32'(i));
    addr = MMIO_TX; w_data = 32'h0000_00AA; w_en = 1'b1; tx_ready = 1'b1; #1;
    checks++;
    if (tx_data !== 8'h01) begin
      errors++; $display("FAIL full_pp_head: got %h expected 01", tx_data);
    end
    step();
    w_en = 1'b0; tx_ready = 1'b0; addr = MMIO_STAT; #1;
    checks++;
    if (r_data !== 32'h0000_0012) begin
      errors++; $display("FAIL full_pp_status: got %h expected 00000012", r_data);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i]) begin
        errors++;
        $display("FAIL full_pp_pop%0d: got valid %b data %h expected valid 1 data %h",
                 i, tx_valid, tx_data, exp_bytes[i]);
      end
      step();
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL full_pp_drained: got tx_valid %b expected 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask
`else
  task automatic test_no_mmio();
    tx_ready = 1'b1;
    store(MMIO_TX, 32'h0000_0005);
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL nommio_tx_tied: got valid %b data %h expected 0 00", tx_valid, tx_data);
    end
    addr = 32'h300; #1;
    checks++;
    if (r_data !== 32'h0000_0005) begin
      errors++; $display("FAIL nommio_alias_load: got %h expected 00000005", r_data);
    end
    addr = MMIO_TX; #1;
    checks++;
    if (r_data !== 32'h0000_0005) begin
      errors++; $display("FAIL nommio_tx_is_ram: got %h expected 00000005", r_data);
    end
    store(MMIO_STAT, 32'h0000_0009);
    addr = 32'h304; #1;
    checks++;
    if (r_data !== 32'h0000_0009) begin
      errors++; $display("FAIL nommio_stat_is_ram: got %h expected 00000009", r_data);
    end
    tx_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
`ifdef DATA_MEM_RESP_MMIO_EN
    tx_ready = 1'b0;
    store(MMIO_TX, 32'h0000_0055);
    store(MMIO_TX, 32'h0000_0066);
    #1;
    checks++;
    if (tx_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_queued: got tx_valid %b expected 1", tx_valid);
    end
`endif
    rst_n = 1'b0;
    addr = 32'h40; w_data = 32'h1111_1111; w_en = 1'b1; #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid: got %b expected 0", tx_valid);
    end
    step();
    w_en = 1'b0;
    rst_n = 1'b1; #1;
`ifdef DATA_MEM_RESP_MMIO_EN
    addr = MMIO_STAT; #1;
    checks++;
    if (r_data !== 32'h0000_0001) begin
      errors++; $display("FAIL rst_mid_status: got %h expected 00000001", r_data);
    end
`endif
    addr = 32'h40; #1;
    checks++;
    if (r_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rst_mid_ram: got %h expected deadbeef", r_data);
    end
  endtask

  initial begin
    test_reset();
    test_ram_roundtrip();
    test_read_old_data();
`ifdef DATA_MEM_RESP_MMIO_EN
    test_fifo_order();
    test_overflow();
    test_full_push_pop();
`else
    test_no_mmio();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
